// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: default sizes, the
// timer source index, FSM state encoding and the default request vector type.
package intc_pkg;

  localparam int NUM_SRC_DEF = 4;
  localparam int ID_W_DEF    = 2;
  localparam int TIMER_SRC   = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intc_state_t;

  typedef logic [NUM_SRC_DEF-1:0] intc_vec_t;

endpackage

// File: rtl/int_controller_if.sv
// Bus between the interrupt controller (slave) and the CPU / request sources
// (master): request lines, mask register access, irq handshake and debug state.
//
// Handshake: irq/irq_id are registered and held while a request is presented.
// The CPU accepts it with a 1-cycle int_ack pulse while irq=1; the controller
// drops irq and raises in_service on the next edge. The CPU ends the handler
// with a 1-cycle int_eret pulse while in_service=1. Pulses in any other state
// are ignored.
interface int_controller_if #(
  parameter int NUM_SRC = intc_pkg::NUM_SRC_DEF,
  parameter int ID_W    = intc_pkg::ID_W_DEF
);
  import intc_pkg::*;

  logic [NUM_SRC-1:0] src_in;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_wdata;
  logic [NUM_SRC-1:0] mask_out;
  logic [NUM_SRC-1:0] pending_out;
  logic               irq;
  logic [ID_W-1:0]    irq_id;
  logic               int_ack;
  logic               int_eret;
  logic               in_service;
  intc_state_t        dbg_state;

  modport master (
    output src_in, mask_we, mask_wdata, int_ack, int_eret,
    input  mask_out, pending_out, irq, irq_id, in_service, dbg_state
  );

  modport slave (
    input  src_in, mask_we, mask_wdata, int_ack, int_eret,
    output mask_out, pending_out, irq, irq_id, in_service, dbg_state
  );

endinterface

// File: rtl/intc_prio_enc.sv
// Combinational priority encoder: lowest set index wins (source 0 = timer).
module intc_prio_enc #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_SRC-1:0] eligible,
  output logic [ID_W-1:0]    win_id,
  output logic               any
);

  // Scan from the top down so the lowest set index is written last.
  always_comb begin
    win_id = '0;
    any    = |eligible;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = ID_W'(i);
    end
  end

endmodule

// File: rtl/int_controller.sv
// Interrupt controller: edge-captures request lines into pending bits, gates
// them with a CPU-writable mask, presents the highest-priority request to the
// CPU and runs the ack/eret handshake (no nesting).
// Optional feature macro: INTC_MISS_CNT_EN adds saturating per-source counters
// of requests that arrived while the same source was still pending.
module int_controller
  import intc_pkg::*;
#(
  parameter int                 NUM_SRC  = NUM_SRC_DEF,
  parameter int                 ID_W     = ID_W_DEF,
  parameter logic [NUM_SRC-1:0] MASK_RST = {NUM_SRC{1'b1}}
`ifdef INTC_MISS_CNT_EN
  ,
  parameter int                 MISS_W   = 8
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  int_controller_if.slave           bus
`ifdef INTC_MISS_CNT_EN
  ,
  output logic [NUM_SRC*MISS_W-1:0] miss_cnt
`endif
);

  intc_state_t        state_q, state_d;
  logic               irq_q, irq_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic               in_service_q, in_service_d;
  logic [NUM_SRC-1:0] src_dly_q, src_dly_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;

  logic [NUM_SRC-1:0] rise_v;
  logic [NUM_SRC-1:0] clr_v;
  logic [NUM_SRC-1:0] eligible;
  logic [ID_W-1:0]    win_id;
  logic               any_elig;
  logic               ack_ok;

  intc_prio_enc #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_prio (
    .eligible(eligible),
    .win_id  (win_id),
    .any     (any_elig)
  );

  // Capture/mask datapath: rising edges set pending, an accepted ack clears
  // the presented bit (set wins on collision); the mask only gates arbitration.
  always_comb begin
    src_dly_d = bus.src_in;
    rise_v    = bus.src_in & ~src_dly_q;
    clr_v     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr_v[i] = ack_ok && (irq_id_q == ID_W'(i));
    end
    pending_d = (pending_q & ~clr_v) | rise_v;
    mask_d    = bus.mask_we ? bus.mask_wdata : mask_q;
    eligible  = pending_q & mask_q;
  end

  // Request/service FSM; ack takes precedence over a request vanishing.
  always_comb begin
    state_d      = state_q;
    irq_d        = irq_q;
    irq_id_d     = irq_id_q;
    in_service_d = in_service_q;
    ack_ok       = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_elig) begin
          state_d  = REQ;
          irq_d    = 1'b1;
          irq_id_d = win_id;
        end
      end
      REQ: begin
        if (bus.int_ack) begin
          ack_ok       = 1'b1;
          state_d      = SERVICE;
          irq_d        = 1'b0;
          in_service_d = 1'b1;
        end else if (!any_elig) begin
          state_d = IDLE;
          irq_d   = 1'b0;
        end else begin
          irq_id_d = win_id;
        end
      end
      SERVICE: begin
        if (bus.int_eret) begin
          state_d      = IDLE;
          in_service_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        irq_d        = 1'b0;
        in_service_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      irq_q        <= 1'b0;
      irq_id_q     <= '0;
      in_service_q <= 1'b0;
      src_dly_q    <= '0;
      pending_q    <= '0;
      mask_q       <= MASK_RST;
    end else begin
      state_q      <= state_d;
      irq_q        <= irq_d;
      irq_id_q     <= irq_id_d;
      in_service_q <= in_service_d;
      src_dly_q    <= src_dly_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
    end
  end

  assign bus.mask_out    = mask_q;
  assign bus.pending_out = pending_q;
  assign bus.irq         = irq_q;
  assign bus.irq_id      = irq_id_q;
  assign bus.in_service  = in_service_q;
  assign bus.dbg_state   = state_q;

`ifdef INTC_MISS_CNT_EN
  logic [MISS_W-1:0] miss_q [NUM_SRC];
  logic [MISS_W-1:0] miss_d [NUM_SRC];

  // Count requests lost to an already-pending bit that is not being cleared.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      miss_d[i] = miss_q[i];
      if (rise_v[i] && pending_q[i] && !clr_v[i] && (miss_q[i] != {MISS_W{1'b1}})) begin
        miss_d[i] = miss_q[i] + 1'b1;
      end
    end
  end

  // Miss counters are cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) miss_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) miss_q[i] <= miss_d[i];
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_miss_out
    assign miss_cnt[g*MISS_W +: MISS_W] = miss_q[g];
  end
`endif

endmodule

// File: tb/tb_int_controller.sv
// Self-checking bench for int_controller: directed scenarios plus randomized
// traffic checked against a set/mask/priority reference model and an
// ack-time scoreboard.
module tb_int_controller;
  import intc_pkg::*;

  localparam int NUM_SRC = NUM_SRC_DEF;
  localparam int ID_W    = ID_W_DEF;
  localparam int W       = NUM_SRC + ID_W;
`ifdef INTC_MISS_CNT_EN
  localparam int MISS_W  = 8;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int_controller_if #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) bus ();

`ifdef INTC_MISS_CNT_EN
  logic [NUM_SRC*MISS_W-1:0] miss_cnt;
`endif

  int_controller #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W),
    .MASK_RST({NUM_SRC{1'b1}})
`ifdef INTC_MISS_CNT_EN
    ,
    .MISS_W  (MISS_W)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef INTC_MISS_CNT_EN
    ,
    .miss_cnt(miss_cnt)
`endif
  );

  // Reference model state
  intc_vec_t      pending_m;
  intc_vec_t      mask_m;
  intc_vec_t      src_cur;
  logic [W-1:0]   exp_q[$];
  int             n_pass = 0;
  int             n_chk  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [ID_W-1:0] lowest(input intc_vec_t v);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (v[i]) return ID_W'(i);
    end
    return '0;
  endfunction

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input intc_vec_t s, input logic ack, input logic [ID_W-1:0] aid,
                       input logic eret, input logic mwe, input intc_vec_t mw);
    intc_vec_t rise;
    intc_vec_t clr;
    rise = s & ~src_cur;
    clr  = '0;
    if (ack) clr[aid] = 1'b1;
    bus.src_in     = s;
    bus.int_ack    = ack;
    bus.int_eret   = eret;
    bus.mask_we    = mwe;
    bus.mask_wdata = mw;
    tick();
    pending_m = (pending_m & ~clr) | rise;
    src_cur   = s;
    if (mwe) mask_m = mw;
    bus.int_ack  = 1'b0;
    bus.int_eret = 1'b0;
    bus.mask_we  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(src_cur, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic pulse(input intc_vec_t s);
    drive(s, 1'b0, '0, 1'b0, 1'b0, '0);
    drive('0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic write_mask(input intc_vec_t m);
    drive(src_cur, 1'b0, '0, 1'b0, 1'b1, m);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    pending_m = '0;
    mask_m    = '1;
    check("rst_irq", bus.irq, 1'b0);
    check("rst_irq_id", bus.irq_id, '0);
    check("rst_pending", bus.pending_out, '0);
    check("rst_mask", bus.mask_out, {NUM_SRC{1'b1}});
    check("rst_in_service", bus.in_service, 1'b0);
    check("rst_state", bus.dbg_state, IDLE);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  // Serve the presented request: ack, optional traffic during the handler, eret.
  task automatic serve(input bit noisy);
    logic [ID_W-1:0] win;
    win = lowest(pending_m & mask_m);
    check("req_irq", bus.irq, 1'b1);
    check("req_id", bus.irq_id, win);
    exp_q.push_back({pending_m, win});
    drive(src_cur, 1'b1, win, 1'b0, 1'b0, '0);
    check("ack_irq_low", bus.irq, 1'b0);
    check("ack_in_service", bus.in_service, 1'b1);
    check("ack_pending", bus.pending_out, pending_m);
    if (noisy) begin
      repeat ($urandom_range(0, 2)) pulse(intc_vec_t'($urandom_range(0, 15)));
    end else begin
      idle(2);
    end
    check("svc_no_irq", bus.irq, 1'b0);
    check("svc_pending", bus.pending_out, pending_m);
    drive(src_cur, 1'b0, '0, 1'b1, 1'b0, '0);
    check("eret_in_service", bus.in_service, 1'b0);
    check("eret_irq_low", bus.irq, 1'b0);
  endtask

  // Scoreboard monitor: every accepted ack must match the oldest expectation.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && bus.int_ack === 1'b1) begin
      check("mon_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("mon_irq", bus.irq, 1'b1);
        check("mon_id", bus.irq_id, e[ID_W-1:0]);
        check("mon_pending", bus.pending_out, e[W-1:ID_W]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    bus.src_in     = '0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    bus.int_ack    = 1'b0;
    bus.int_eret   = 1'b0;
    pending_m      = '0;
    mask_m         = '1;
    src_cur        = '0;
    repeat (3) @(posedge clk);
    #1;
    apply_reset();

    // Timer pulse: pending after the capture edge, irq one edge later.
    drive(4'b0001, 1'b0, '0, 1'b0, 1'b0, '0);
    check("t1_pending", bus.pending_out, 4'b0001);
    check("t1_irq_not_yet", bus.irq, 1'b0);
    drive('0, 1'b0, '0, 1'b0, 1'b0, '0);
    serve(1'b0);
    idle(1);
    check("t1_quiet", bus.irq, 1'b0);

    // Simultaneous requests: lower index first, then the other one.
    drive(4'b0110, 1'b0, '0, 1'b0, 1'b0, '0);
    drive('0, 1'b0, '0, 1'b0, 1'b0, '0);
    serve(1'b0);
    idle(1);
    serve(1'b0);
    idle(1);

    // Masked source is captured but not presented until unmasked.
    write_mask(4'b1110);
    pulse(4'b0001);
    idle(1);
    check("t3_pending", bus.pending_out, 4'b0001);
    check("t3_masked", bus.irq, 1'b0);
    write_mask(4'b1111);
    idle(1);
    serve(1'b0);
    idle(1);

    // New edge collides with the ack of the same source: set wins.
    pulse(4'b0010);
    check("t4_id", bus.irq_id, 2'd1);
    exp_q.push_back({pending_m, 2'd1});
    drive(4'b0010, 1'b1, 2'd1, 1'b0, 1'b0, '0);
    check("t4_pending_kept", bus.pending_out, 4'b0010);
    check("t4_in_service", bus.in_service, 1'b1);
    drive('0, 1'b0, '0, 1'b0, 1'b0, '0);
    drive('0, 1'b0, '0, 1'b1, 1'b0, '0);
    check("t4_eret_irq_low", bus.irq, 1'b0);
    idle(1);
    serve(1'b0);
    idle(1);

    // Asynchronous reset in REQ with two pending sources and a non-default mask.
    write_mask(4'b0101);
    pulse(4'b0101);
    check("t5_req", bus.irq, 1'b1);
    check("t5_pending", bus.pending_out, 4'b0101);
    apply_reset();

    // Randomized traffic against the reference model.
    repeat (40) begin
      if ($urandom_range(0, 3) == 0) write_mask(intc_vec_t'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 3)) begin
        drive(intc_vec_t'($urandom_range(0, 15)), 1'b0, '0, 1'b0, 1'b0, '0);
        if ($urandom_range(0, 1) == 1) drive('0, 1'b0, '0, 1'b0, 1'b0, '0);
      end
      drive('0, 1'b0, '0, 1'b0, 1'b0, '0);
      idle(2);
      check("rnd_pending", bus.pending_out, pending_m);
      check("rnd_mask", bus.mask_out, mask_m);
      check("rnd_irq", bus.irq, |(pending_m & mask_m));
      if ((|(pending_m & mask_m)) && $urandom_range(0, 3) != 0) serve(1'b1);
    end

    // Drain everything still pending.
    write_mask('1);
    idle(2);
    repeat (NUM_SRC + 4) begin
      if (|pending_m) begin
        serve(1'b0);
        idle(1);
      end
    end
    check("drain_pending", bus.pending_out, '0);

`ifdef INTC_MISS_CNT_EN
    // Lost-request counting and saturation on source 3.
    apply_reset();
    repeat (3) pulse(4'b1000);
    check("t6_miss3_two", miss_cnt[3*MISS_W +: MISS_W], 8'd2);
    check("t6_miss0_zero", miss_cnt[0 +: MISS_W], 8'd0);
    repeat (297) pulse(4'b1000);
    check("t6_miss3_sat", miss_cnt[3*MISS_W +: MISS_W], 8'd255);
    serve(1'b0);
    idle(1);
    check("t6_miss3_hold", miss_cnt[3*MISS_W +: MISS_W], 8'd255);
`endif

    idle(2);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
